seg7_scan_ctrl: RTL and testbench

Time-multiplexing controller for the two-digit 7-segment display driven by the mod-60 counter's chuc/donvi BCD outputs.
- Shares one segment bus between the units and tens digits by scanning them alternately.
- Inserts a blanking gap between digits to prevent ghosting.
- Snapshots both digits once per frame so the display never tears.
- Sits between the counter and the board pins.

---
 rtl/seg7_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Two-digit 7-segment scan controller: alternates units/tens on a shared segment
// bus with blanking gaps, displaying a per-frame snapshot of the BCD inputs.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV   = 4,
    parameter int BLANK_CYC  = 1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] chuc,
    input  logic [3:0] donvi,
    input  logic       lz_blank,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_done
);

    localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHOW_DV  = 3'd1,
        BLANK_DV = 3'd2,
        SHOW_CH  = 3'd3,
        BLANK_CH = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [3:0]    snap_dv_q, snap_ch_q;
    logic          frame_done_q;
    logic          frame_end;
    logic          load_snap;
    logic [6:0]    seg_l;
    logic [1:0]    an_l;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // A completed frame always pulses frame_done; dropping en earlier aborts silently.
    always_comb begin
        state_d   = state_q;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) state_d = SHOW_DV;
            end
            SHOW_DV: begin
                if (!en)                     state_d = IDLE;
                else if (cnt_q == SHOW_LAST) state_d = (BLANK_CYC == 0) ? SHOW_CH : BLANK_DV;
            end
            BLANK_DV: begin
                if (!en)                      state_d = IDLE;
                else if (cnt_q == BLANK_LAST) state_d = SHOW_CH;
            end
            SHOW_CH: begin
                if (cnt_q == SHOW_LAST && BLANK_CYC == 0) begin
                    frame_end = 1'b1;
                    state_d   = en ? SHOW_DV : IDLE;
                end else if (!en) begin
                    state_d = IDLE;
                end else if (cnt_q == SHOW_LAST) begin
                    state_d = BLANK_CH;
                end
            end
            BLANK_CH: begin
                if (cnt_q == BLANK_LAST) begin
                    frame_end = 1'b1;
                    state_d   = en ? SHOW_DV : IDLE;
                end else if (!en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_snap = (state_d == SHOW_DV) && (state_q != SHOW_DV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            snap_dv_q    <= '0;
            snap_ch_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= frame_end;
            if (state_d != state_q || state_q == IDLE) cnt_q <= '0;
            else                                       cnt_q <= cnt_q + 1'b1;
            if (load_snap) begin
                snap_dv_q <= donvi;
                snap_ch_q <= chuc;
            end
        end
    end

    // lz_blank acts live on the tens anode; it never changes slot timing.
    always_comb begin
        seg_l = '0;
        an_l  = '0;
        case (state_q)
            SHOW_DV: begin
                an_l  = 2'b01;
                seg_l = decode(snap_dv_q);
            end
            SHOW_CH: begin
                an_l  = (lz_blank && snap_ch_q == 4'd0) ? 2'b00 : 2'b10;
                seg_l = decode(snap_ch_q);
            end
            default: begin
                seg_l = '0;
                an_l  = '0;
            end
        endcase
    end

    assign seg        = ACTIVE_LOW ? ~seg_l : seg_l;
    assign an         = ACTIVE_LOW ? ~an_l  : an_l;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random traffic against a
// frame-position reference model; a second instance checks the inverted pins.
module tb_seg7_scan_ctrl;

    localparam int SD = 4;
    localparam int BC = 1;
    localparam int FL = 2 * (SD + BC);

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       en       = 1'b1;
    logic [3:0] chuc     = 4'd4;
    logic [3:0] donvi    = 4'd7;
    logic       lz_blank = 1'b0;
    logic [6:0] seg, seg_n;
    logic [1:0] an, an_n;
    logic       fd, fd_n;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    // Reference model: frame active flag, position within frame, snapshot.
    bit         m_act = 1'b0;
    int         m_pos = 0;
    logic [3:0] m_dv  = '0;
    logic [3:0] m_ch  = '0;
    bit         m_fd  = 1'b0;
    logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .chuc(chuc), .donvi(donvi),
        .lz_blank(lz_blank), .seg(seg), .an(an), .frame_done(fd)
    );

    seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1'b1)) dut_n (
        .clk(clk), .rst_n(rst_n), .en(en), .chuc(chuc), .donvi(donvi),
        .lz_blank(lz_blank), .seg(seg_n), .an(an_n), .frame_done(fd_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        m_fd = 1'b0;
        if (!rst_n) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (en) begin
                m_act = 1'b1; m_pos = 0; m_dv = donvi; m_ch = chuc;
            end
        end else if (m_pos == FL - 1) begin
            m_fd = 1'b1;
            if (en) begin
                m_pos = 0; m_dv = donvi; m_ch = chuc;
            end else begin
                m_act = 1'b0;
            end
        end else if (!en) begin
            m_act = 1'b0;
        end else begin
            m_pos++;
        end
    endtask

    function automatic logic [9:0] model_out();
        logic [1:0] a;
        logic [6:0] s;
        a = 2'b00;
        s = 7'h00;
        if (m_act) begin
            if (m_pos < SD) begin
                a = 2'b01;
                s = dec_tab[m_dv];
            end else if (m_pos >= SD + BC && m_pos < 2 * SD + BC) begin
                s = dec_tab[m_ch];
                a = (lz_blank && m_ch == 4'd0) ? 2'b00 : 2'b10;
            end
        end
        return {m_fd, a, s};
    endfunction

    task automatic check_outputs();
        logic [9:0] e;
        logic [6:0] s_inv;
        logic [1:0] a_inv;
        e     = exp_q.pop_front();
        s_inv = ~e[6:0];
        a_inv = ~e[8:7];
        check_eq("seg", 32'(seg), 32'(e[6:0]));
        check_eq("an", 32'(an), 32'(e[8:7]));
        check_eq("frame_done", 32'(fd), 32'(e[9]));
        check_eq("seg_pin_inv", 32'(seg_n), 32'(s_inv));
        check_eq("an_pin_inv", 32'(an_n), 32'(a_inv));
        check_eq("frame_done_inv_inst", 32'(fd_n), 32'(e[9]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
        exp_q.push_back(model_out());
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_pos(input string tag, input int p);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 3 * FL && !hit; i++) begin
            step();
            if (m_act && m_pos == p) hit = 1'b1;
        end
        check_eq(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        // Reset held across two edges, released between edges.
        run(2);
        rst_n = 1'b1;
        run(3 * FL);

        // Units input changes mid tens slot; visible only next frame.
        wait_pos("reach_show_ch_a", SD + BC + 1);
        donvi = 4'd8;
        run(2 * FL);

        // Leading-zero suppression on and off.
        chuc = 4'd0; donvi = 4'd5; lz_blank = 1'b1;
        run(2 * FL);
        lz_blank = 1'b0;
        run(2 * FL);

        // Invalid tens value shows a dash.
        chuc = 4'd12; donvi = 4'd3;
        run(2 * FL);

        // Abort during units blanking, then re-enable with fresh inputs.
        wait_pos("reach_blank_dv", SD);
        en = 1'b0;
        run(3);
        chuc = 4'd9; donvi = 4'd1; en = 1'b1;
        run(FL + 2);

        // Asynchronous reset mid tens slot.
        wait_pos("reach_show_ch_b", SD + BC + 2);
        #1 rst_n = 1'b0;
        #1;
        m_act = 1'b0;
        m_fd  = 1'b0;
        check_eq("rst_seg", 32'(seg), 32'h00);
        check_eq("rst_an", 32'(an), 32'h0);
        check_eq("rst_fd", 32'(fd), 32'h0);
        check_eq("rst_seg_pin_inv", 32'(seg_n), 32'h7F);
        check_eq("rst_an_pin_inv", 32'(an_n), 32'h3);
        run(2);
        rst_n = 1'b1;
        run(FL);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step();
            en = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 7) == 0) chuc = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) donvi = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) lz_blank = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) chuc = 4'd0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
